// File: rtl/mem_bus_responder.sv
// Memory-module end of the system bus: synchronizes the strobes, translates NB/page to a
// physical frame, drives the parity-protected RAM and answers OK / EN / PE under the 4-phase handshake.
module mem_bus_responder #(
    parameter int FRAME_BITS     = 3,
    parameter int RAM_LAT        = 2,
    parameter int PRESET_PAGES   = 2,
    parameter bit EN_ON_UNMAPPED = 1'b0
) (
    input  logic                   clk_sys,
    input  logic                   clo,
    input  logic                   dw_,
    input  logic                   dr_,
    input  logic                   ds_,
    input  logic [15:0]            ad,
    input  logic [3:0]             nb,
    input  logic [15:0]            dt_in,
    output logic [15:0]            dt_out,
    output logic                   dt_oe,
    output logic                   rok_,
    output logic                   ren_,
    output logic                   rpe_,
    output logic [FRAME_BITS+11:0] ram_addr,
    output logic                   ram_we,
    output logic [16:0]            ram_din,
    input  logic [16:0]            ram_dout
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_RESPOND, S_RELEASE} state_t;
    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_CONFIG} op_t;
    typedef enum logic [1:0] {ANS_OK, ANS_EN, ANS_PE} ans_t;

    state_t state_q, state_d;
    op_t    op_q, op_d;
    ans_t   ans_q, ans_d;
    logic [3:0]  nb_q, nb_d, page_q, page_d;
    logic [11:0] off_q, off_d;
    logic [15:0] dt_q, dt_d, dt_out_q, dt_out_d;
    logic [1:0]  cnt_q, cnt_d;

    // {ds_, dr_, dw_}, two-flop synchronizer, idle-high
    logic [2:0] strb_s1_q, strb_s2_q;
    logic       dw_act, dr_act, ds_act, bus_idle;

    logic [255:0]                 map_vld_q;
    logic [255:0][FRAME_BITS-1:0] map_frm_q;
    logic [7:0]                   map_idx, cfg_idx;
    logic                         map_vld, cfg_we;
    logic [FRAME_BITS-1:0]        map_frm;

    assign dw_act   = ~strb_s2_q[0];
    assign dr_act   = ~strb_s2_q[1];
    assign ds_act   = ~strb_s2_q[2];
    assign bus_idle = ~dw_act & ~dr_act;

    always_ff @(posedge clk_sys or posedge clo) begin
        if (clo) begin
            strb_s1_q <= 3'b111;
            strb_s2_q <= 3'b111;
        end else begin
            strb_s1_q <= {ds_, dr_, dw_};
            strb_s2_q <= strb_s1_q;
        end
    end

    // Map index is {NB, page}; config takes NB from dt_in[3:0] and page from dt_in[7:4]
    assign map_idx = {nb_q, page_q};
    assign cfg_idx = {dt_q[3:0], dt_q[7:4]};
    assign map_vld = map_vld_q[map_idx];
    assign map_frm = map_frm_q[map_idx];
    assign cfg_we  = (state_q == S_DECODE) && (op_q == OP_CONFIG);

    always_ff @(posedge clk_sys or posedge clo) begin
        if (clo) begin
            for (int i = 0; i < 256; i++) begin
                map_vld_q[i] <= (i < PRESET_PAGES);
                map_frm_q[i] <= (i < PRESET_PAGES) ? FRAME_BITS'(i) : '0;
            end
        end else if (cfg_we) begin
            map_vld_q[cfg_idx] <= dt_q[15];
            map_frm_q[cfg_idx] <= dt_q[8 +: FRAME_BITS];
        end
    end

    always_ff @(posedge clk_sys or posedge clo) begin
        if (clo) begin
            state_q  <= S_IDLE;
            op_q     <= OP_WRITE;
            ans_q    <= ANS_OK;
            nb_q     <= '0;
            page_q   <= '0;
            off_q    <= '0;
            dt_q     <= '0;
            dt_out_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ans_q    <= ans_d;
            nb_q     <= nb_d;
            page_q   <= page_d;
            off_q    <= off_d;
            dt_q     <= dt_d;
            dt_out_q <= dt_out_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ans_d    = ans_q;
        nb_d     = nb_q;
        page_d   = page_q;
        off_d    = off_q;
        dt_d     = dt_q;
        dt_out_d = dt_out_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (dw_act && dr_act) begin
                    state_d = S_RELEASE;
                end else if (dw_act || dr_act) begin
                    // Bus bit 0 is the MSB, so ad[0:3] on the bus is ad[15:12] here
                    op_d    = dw_act ? (ds_act ? OP_CONFIG : OP_WRITE) : OP_READ;
                    nb_d    = nb;
                    page_d  = ad[15:12];
                    off_d   = ad[11:0];
                    dt_d    = dt_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ans_d = ANS_OK;
                cnt_d = '0;
                if (op_q == OP_CONFIG) begin
                    state_d = S_RESPOND;
                end else if (!map_vld) begin
                    ans_d   = ANS_EN;
                    state_d = EN_ON_UNMAPPED ? S_RESPOND : S_RELEASE;
                end else if (op_q == OP_WRITE) begin
                    state_d = S_RESPOND;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(RAM_LAT - 1)) begin
                    dt_out_d = ram_dout[15:0];
                    ans_d    = (^ram_dout) ? ANS_OK : ANS_PE;
                    state_d  = S_RESPOND;
                end
            end
            S_RESPOND, S_RELEASE: begin
                if (bus_idle) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rok_   = 1'b1;
        ren_   = 1'b1;
        rpe_   = 1'b1;
        dt_oe  = 1'b0;
        ram_we = (state_q == S_DECODE) && (op_q == OP_WRITE) && map_vld;
        if (state_q == S_RESPOND) begin
            rok_  = (ans_q != ANS_OK);
            ren_  = (ans_q != ANS_EN);
            rpe_  = (ans_q != ANS_PE);
            dt_oe = (op_q == OP_READ) && (ans_q != ANS_EN);
        end
    end

    assign ram_addr = {map_frm, off_q};
    assign ram_din  = {~^dt_q, dt_q};
    assign dt_out   = dt_out_q;

endmodule
